// File: rtl/sync_burst_gen.sv
// Wake-up burst generator: synchronises comp_out into clki, detects the chosen edge and,
// when qualified by WU_valid, emits one gated data-clock burst with preamble and T_0/T_1 phases.
module sync_burst_gen #(
  parameter int SYNC_STAGES = 3,
  parameter int DIV         = 100,
  parameter int NUM_BITS    = 1000,
  parameter int PRE_BITS    = 192,
  parameter int CNT_W       = 20,
  parameter int EDGE_MODE   = 0
) (
  input  logic             clki,
  input  logic             rst,
  input  logic             comp_out,
  input  logic             WU_valid,
  input  logic             abort,
  output logic             data_clk,
  output logic             data_clk_enb,
  output logic             T_0,
  output logic             T_1,
  output logic             preamble,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             done
);

  localparam int                MW      = $clog2(SYNC_STAGES + 1);
  localparam logic [MW-1:0]     MASK_IV = MW'(SYNC_STAGES);
  localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0]  NB      = CNT_W'(NUM_BITS);
  localparam logic [CNT_W-1:0]  PB      = CNT_W'(PRE_BITS);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DONE} state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [MW-1:0]          r_mask;
  logic [CNT_W-1:0]       r_ph;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic                   r_dclk, r_enb, r_t0, r_t1, r_pre, r_done;

  logic                   w_new, w_old, w_rise, w_fall, w_edge, w_trig, w_ph_end;
  logic [CNT_W-1:0]       w_cnt_nxt;

  always_ff @(posedge clki or posedge rst) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], comp_out};
  end

  // Edges are ignored until the chain has refilled after reset, so a level
  // held across reset release cannot look like a fresh edge.
  always_ff @(posedge clki or posedge rst) begin
    if (rst)                 r_mask <= MASK_IV;
    else if (r_mask != '0)   r_mask <= r_mask - 1'b1;
  end

  assign w_new  = r_sync[SYNC_STAGES-2];
  assign w_old  = r_sync[SYNC_STAGES-1];
  assign w_rise = w_new & ~w_old;
  assign w_fall = ~w_new & w_old;
  assign w_edge = (EDGE_MODE == 0) ? w_rise :
                  (EDGE_MODE == 1) ? w_fall : (w_rise | w_fall);

  assign w_trig    = w_edge & (r_mask == '0) & WU_valid & ~abort & (r_state == S_IDLE);
  assign w_ph_end  = (r_ph == HALF_M1);
  assign w_cnt_nxt = r_bit_cnt + 1'b1;

  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ph      <= '0;
      r_bit_cnt <= '0;
      r_dclk    <= 1'b0;
      r_enb     <= 1'b0;
      r_t0      <= 1'b0;
      r_t1      <= 1'b0;
      r_pre     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_trig) begin
            r_state   <= (PRE_BITS > 0) ? S_PRE : S_DATA;
            r_enb     <= 1'b1;
            r_dclk    <= 1'b0;
            r_bit_cnt <= '0;
            r_ph      <= '0;
            r_t0      <= 1'b0;
            r_t1      <= 1'b0;
            r_pre     <= (PRE_BITS > 0);
          end
        end
        S_PRE, S_DATA: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_enb   <= 1'b0;
            r_dclk  <= 1'b0;
            r_t0    <= 1'b0;
            r_t1    <= 1'b0;
            r_pre   <= 1'b0;
          end else if (w_ph_end) begin
            r_ph <= '0;
            if (!r_dclk) begin
              r_dclk <= 1'b1;
              if (r_state == S_DATA) begin
                r_t1 <= ~r_t1;
                r_t0 <= r_t1;
              end
            end else begin
              r_dclk    <= 1'b0;
              r_bit_cnt <= w_cnt_nxt;
              if (w_cnt_nxt == NB) begin
                r_state <= S_DONE;
                r_enb   <= 1'b0;
                r_t0    <= 1'b0;
                r_t1    <= 1'b0;
                r_pre   <= 1'b0;
                r_done  <= 1'b1;
              end else if (w_cnt_nxt >= PB) begin
                r_state <= S_DATA;
                r_pre   <= 1'b0;
              end
            end
          end else begin
            r_ph <= r_ph + 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_clk     = r_dclk;
  assign data_clk_enb = r_enb;
  assign T_0          = r_t0;
  assign T_1          = r_t1;
  assign preamble     = r_pre;
  assign bit_cnt      = r_bit_cnt;
  assign done         = r_done;

endmodule

// File: tb/tb_sync_burst_gen.sv
// Directed bench for sync_burst_gen: table of edge/qualifier scenarios on a rising-edge
// instance, plus hand sequences for retrigger, abort, reset and a both-edge instance.
module tb_sync_burst_gen;
  localparam int DIV = 4;
  localparam int NB  = 8;
  localparam int PB  = 3;
  localparam int NBB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_comp = 1'b0, a_wu = 1'b0, a_abort = 1'b0;
  logic        a_dc, a_enb, a_t0, a_t1, a_pre, a_done;
  logic [19:0] a_cnt;
  logic        b_comp = 1'b0, b_wu = 1'b0, b_abort = 1'b0;
  logic        b_dc, b_enb, b_t0, b_t1, b_pre, b_done;
  logic [19:0] b_cnt;

  sync_burst_gen #(.SYNC_STAGES(3), .DIV(DIV), .NUM_BITS(NB), .PRE_BITS(PB),
                   .CNT_W(20), .EDGE_MODE(0)) u_a (
    .clki(clk), .rst(rst), .comp_out(a_comp), .WU_valid(a_wu), .abort(a_abort),
    .data_clk(a_dc), .data_clk_enb(a_enb), .T_0(a_t0), .T_1(a_t1),
    .preamble(a_pre), .bit_cnt(a_cnt), .done(a_done));

  sync_burst_gen #(.SYNC_STAGES(3), .DIV(DIV), .NUM_BITS(NBB), .PRE_BITS(0),
                   .CNT_W(20), .EDGE_MODE(2)) u_b (
    .clki(clk), .rst(rst), .comp_out(b_comp), .WU_valid(b_wu), .abort(b_abort),
    .data_clk(b_dc), .data_clk_enb(b_enb), .T_0(b_t0), .T_1(b_t1),
    .preamble(b_pre), .bit_cnt(b_cnt), .done(b_done));

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  int m_enb, m_done, m_rise, m_first, m_bad, m_pre_seen;

  task automatic mon_a(input int ncyc);
    logic pdc;
    int   k;
    pdc = 1'b0; m_enb = 0; m_done = 0; m_rise = 0; m_first = -1; m_bad = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (a_dc && !pdc) begin
        k = m_rise;
        if (m_rise == 0) m_first = m_enb;
        chk("a_pre_at_rise", a_pre, (k < PB) ? 1 : 0);
        chk("a_t1_at_rise", a_t1, (k >= PB && (k - PB) % 2 == 0) ? 1 : 0);
        chk("a_t0_at_rise", a_t0, (k >= PB && (k - PB) % 2 == 1) ? 1 : 0);
        chk("a_cnt_at_rise", a_cnt, k);
        m_rise++;
      end
      if (a_enb) m_enb++;
      else if (a_dc || a_t0 || a_t1 || a_pre) m_bad++;
      if (a_done) begin
        m_done++;
        chk("a_done_cnt", a_cnt, NB);
        chk("a_done_enb", a_enb, 0);
      end
      pdc = a_dc;
    end
  endtask

  task automatic mon_b(input int ncyc);
    logic pdc;
    pdc = 1'b0; m_enb = 0; m_done = 0; m_rise = 0; m_pre_seen = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (b_dc && !pdc) begin
        chk("b_t1_at_rise", b_t1, (m_rise % 2 == 0) ? 1 : 0);
        chk("b_t0_at_rise", b_t0, (m_rise % 2 == 1) ? 1 : 0);
        m_rise++;
      end
      if (b_enb)  m_enb++;
      if (b_pre)  m_pre_seen++;
      if (b_done) m_done++;
      pdc = b_dc;
    end
  endtask

  typedef struct {
    logic c0, c1, wu, ab;
    int   enb, dn, rise, cnt;
  } vec_t;
  vec_t tab[5];

  int wait_n;

  initial begin
    tab[0] = '{1'b0, 1'b1, 1'b1, 1'b0, NB*DIV, 1, NB, NB};  // rising + WU -> burst
    tab[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0, NB};        // falling edge ignored
    tab[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, NB};        // no WU_valid
    tab[3] = '{1'b0, 1'b1, 1'b1, 1'b0, NB*DIV, 1, NB, NB};  // burst again
    tab[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 0, NB};        // abort beats trigger

    repeat (3) @(negedge clk);
    chk("rst_enb", a_enb, 0);
    chk("rst_dclk", a_dc, 0);
    chk("rst_t", {a_t0, a_t1}, 0);
    chk("rst_pre_done", {a_pre, a_done}, 0);
    chk("rst_cnt", a_cnt, 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      a_wu = 1'b0; a_abort = 1'b0; a_comp = tab[i].c0;
      repeat (8) @(negedge clk);
      a_wu = tab[i].wu; a_abort = tab[i].ab; a_comp = tab[i].c1;
      mon_a(45);
      a_wu = 1'b0; a_abort = 1'b0;
      chk($sformatf("v%0d_enb_cycles", i), m_enb, tab[i].enb);
      chk($sformatf("v%0d_done", i), m_done, tab[i].dn);
      chk($sformatf("v%0d_rises", i), m_rise, tab[i].rise);
      chk($sformatf("v%0d_cnt", i), a_cnt, tab[i].cnt);
      chk($sformatf("v%0d_idle_clean", i), m_bad, 0);
      if (tab[i].rise > 0) chk($sformatf("v%0d_first_rise", i), m_first, DIV/2);
    end

    // retrigger mid-burst is ignored
    a_comp = 1'b0; repeat (8) @(negedge clk);
    a_wu = 1'b1; a_comp = 1'b1;
    fork
      mon_a(45);
      begin
        repeat (12) @(negedge clk); a_comp = 1'b0;
        repeat (3)  @(negedge clk); a_comp = 1'b1;
      end
    join
    a_wu = 1'b0;
    chk("retrig_enb_cycles", m_enb, NB*DIV);
    chk("retrig_done", m_done, 1);

    // abort during bit 5
    a_comp = 1'b0; repeat (8) @(negedge clk);
    a_wu = 1'b1; a_comp = 1'b1;
    wait_n = 0;
    do begin @(negedge clk); wait_n++; end while (!(a_enb && a_cnt == 5) && wait_n < 80);
    chk("abort_reach_bit5", (a_enb && a_cnt == 5) ? 1 : 0, 1);
    repeat (2) @(negedge clk);
    chk("abort_pre_t1", a_t1, 1);
    a_abort = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    chk("abort_enb", a_enb, 0);
    chk("abort_dclk", a_dc, 0);
    chk("abort_t", {a_t0, a_t1, a_pre}, 0);
    chk("abort_cnt_hold", a_cnt, 5);
    mon_a(30);
    chk("abort_no_done", m_done, 0);
    chk("abort_stays_idle", m_enb, 0);
    a_wu = 1'b0; a_comp = 1'b0; repeat (8) @(negedge clk);
    a_wu = 1'b1; a_comp = 1'b1;
    wait_n = 0;
    do begin @(negedge clk); wait_n++; end while (!a_enb && wait_n < 20);
    chk("restart_enb", a_enb, 1);
    chk("restart_cnt0", a_cnt, 0);
    repeat (40) @(negedge clk);
    a_wu = 1'b0;
    chk("restart_full_cnt", a_cnt, NB);

    // reset mid-burst with comp_out held high through release
    a_comp = 1'b0; repeat (8) @(negedge clk);
    a_wu = 1'b1; a_comp = 1'b1;
    repeat (12) @(negedge clk);
    chk("rst_mid_active", a_enb, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_enb", a_enb, 0);
    chk("rst_mid_outs", {a_dc, a_t0, a_t1, a_pre, a_done}, 0);
    chk("rst_mid_cnt", a_cnt, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mon_a(40);
    a_wu = 1'b0;
    chk("rst_rel_no_burst", m_enb, 0);
    chk("rst_rel_no_done", m_done, 0);

    // both-edge instance without preamble
    b_wu = 1'b1; b_comp = 1'b1;
    mon_b(30);
    chk("b_rise_enb", m_enb, NBB*DIV);
    chk("b_rise_bits", m_rise, NBB);
    chk("b_rise_done", m_done, 1);
    chk("b_rise_nopre", m_pre_seen, 0);
    chk("b_rise_cnt", b_cnt, NBB);
    b_comp = 1'b0;
    mon_b(30);
    b_wu = 1'b0;
    chk("b_fall_enb", m_enb, NBB*DIV);
    chk("b_fall_done", m_done, 1);
    chk("b_fall_nopre", m_pre_seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
